// File: rtl/fnd_pkg.sv
// ============================================================================
// Module   : fnd_pkg
// Purpose  : Shared constants and FSM state type for the FND scan path.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fnd_pkg;

    localparam int DIGIT_NUM = 4;
    localparam int BCD_W     = 4;
    localparam int BIN_W     = 14;
    localparam int CONV_ITER = 14;
    localparam int BCD_TOT_W = DIGIT_NUM * BCD_W;
    localparam int SHIFT_W   = BCD_TOT_W + BIN_W;

    localparam logic [BIN_W-1:0] VALUE_MAX  = 14'd9999;
    localparam logic [BCD_W-1:0] BLANK_CODE = 4'hF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } conv_state_e;

endpackage : fnd_pkg

`default_nettype wire

// File: rtl/fnd_scan_controller_bin2bcd_seq.sv
// ============================================================================
// Module   : bin2bcd_seq
// Purpose  : Sequential double-dabble converter, 14-bit binary to 4 BCD
//            digits. Inputs above 9999 are clamped and flagged.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bin2bcd_seq
    import fnd_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_valid,
    input  logic [BIN_W-1:0]     i_value,
    output logic                 o_ready,
    output logic                 o_done,
    output logic                 o_ovf,
    output logic [BCD_TOT_W-1:0] o_bcd
);

    localparam logic [3:0] ITER_LAST = 4'(CONV_ITER - 1);

    conv_state_e          state_q;
    logic [SHIFT_W-1:0]   shift_q;
    logic [SHIFT_W-1:0]   shift_d;
    logic [BCD_TOT_W-1:0] bcd_adj_d;
    logic [3:0]           iter_q;
    logic                 ready_q;
    logic                 done_q;
    logic                 ovf_q;
    logic [BIN_W-1:0]     clamp_d;
    logic                 ovf_d;

    // Saturate out-of-range inputs to the largest displayable value
    always_comb begin
        ovf_d   = (i_value > VALUE_MAX);
        clamp_d = ovf_d ? VALUE_MAX : i_value;
    end

    // One double-dabble step: add 3 to every nibble >= 5, then shift left
    always_comb begin
        bcd_adj_d = shift_q[SHIFT_W-1:BIN_W];
        for (int i = 0; i < DIGIT_NUM; i++) begin
            if (bcd_adj_d[i*BCD_W +: BCD_W] >= 4'd5) begin
                bcd_adj_d[i*BCD_W +: BCD_W] = bcd_adj_d[i*BCD_W +: BCD_W] + 4'd3;
            end
        end
        shift_d = {bcd_adj_d, shift_q[BIN_W-1:0]} << 1;
    end

    // Conversion FSM: accept in IDLE, 14 shift steps, one commit cycle
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            iter_q  <= '0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_valid) begin
                        state_q <= SHIFT;
                        shift_q <= {{BCD_TOT_W{1'b0}}, clamp_d};
                        iter_q  <= '0;
                        ready_q <= 1'b0;
                        ovf_q   <= ovf_d;
                    end
                end
                SHIFT: begin
                    shift_q <= shift_d;
                    iter_q  <= iter_q + 4'd1;
                    if (iter_q == ITER_LAST) begin
                        state_q <= COMMIT;
                        done_q  <= 1'b1;
                    end
                end
                COMMIT: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign o_ready = ready_q;
    assign o_done  = done_q;
    assign o_ovf   = ovf_q;
    assign o_bcd   = shift_q[SHIFT_W-1:BIN_W];

endmodule : bin2bcd_seq

`default_nettype wire

// File: rtl/fnd_scan_controller.sv
// ============================================================================
// Module   : fnd_scan_controller
// Purpose  : Converts a binary value to BCD and time-multiplexes the four
//            digits onto a shared BCD bus with active-low digit selects.
//            Optional leading-zero blanking when FND_LZB_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fnd_scan_controller
    import fnd_pkg::*;
#(
    parameter int SCAN_DIV = 100000,
    parameter int VALUE_W  = 14
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_en,
    input  logic [VALUE_W-1:0] i_value,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [3:0]         i_dp_mask,
    output logic [3:0]         o_bcd,
    output logic [3:0]         o_digit_sel,
    output logic               o_dp,
    output logic               o_ovf
);

    localparam int             PRE_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);

    logic [PRE_W-1:0]     pre_q;
    logic [1:0]           idx_q;
    logic [BCD_TOT_W-1:0] disp_q;
    logic [BCD_TOT_W-1:0] conv_bcd;
    logic                 conv_done;
    logic [BCD_W-1:0]     bcd_d;
    logic [BCD_W-1:0]     nib_d;
    logic [3:0]           bcd_q;
    logic [3:0]           sel_q;
    logic                 dp_q;

    bin2bcd_seq u_conv (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_valid   (i_valid),
        .i_value   (i_value[BIN_W-1:0]),
        .o_ready   (o_ready),
        .o_done    (conv_done),
        .o_ovf     (o_ovf),
        .o_bcd     (conv_bcd)
    );

    // Display register: only a finished conversion replaces what is shown
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            disp_q <= '0;
        end else if (conv_done) begin
            disp_q <= conv_bcd;
        end
    end

    // Slot prescaler and digit index; both parked at zero while disabled
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            pre_q <= '0;
            idx_q <= '0;
        end else if (!i_en) begin
            pre_q <= '0;
            idx_q <= '0;
        end else if (pre_q == PRE_LAST) begin
            pre_q <= '0;
            idx_q <= idx_q + 2'd1;
        end else begin
            pre_q <= pre_q + 1'b1;
        end
    end

    // Select the active nibble and optionally blank zeros above the top digit
    always_comb begin
        nib_d = disp_q[{idx_q, 2'b00} +: BCD_W];
`ifdef FND_LZB_EN
        case (idx_q)
            2'd1:    bcd_d = (disp_q[15:4]  == 12'd0) ? BLANK_CODE : nib_d;
            2'd2:    bcd_d = (disp_q[15:8]  == 8'd0)  ? BLANK_CODE : nib_d;
            2'd3:    bcd_d = (disp_q[15:12] == 4'd0)  ? BLANK_CODE : nib_d;
            default: bcd_d = nib_d;
        endcase
`else
        bcd_d = nib_d;
`endif
    end

    // Registered pad-side outputs derived from the current index
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            bcd_q <= 4'h0;
            sel_q <= 4'b1111;
            dp_q  <= 1'b1;
        end else begin
            bcd_q <= bcd_d;
            if (i_en) begin
                sel_q <= ~(4'b0001 << idx_q);
                dp_q  <= ~i_dp_mask[idx_q];
            end else begin
                sel_q <= 4'b1111;
                dp_q  <= 1'b1;
            end
        end
    end

    assign o_bcd       = bcd_q;
    assign o_digit_sel = sel_q;
    assign o_dp        = dp_q;

endmodule : fnd_scan_controller

`default_nettype wire
